// File: rtl/seq_signed_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives the request; the slave returns status and results.
interface seq_signed_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: sign-magnitude wrapper around a non-restoring
// shift/add-subtract core, one quotient bit per clock, fixed latency WIDTH+1.
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH:0]   d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_pend_q, dz_pend_d;
    logic             ov_pend_q, ov_pend_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             done_q, done_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   p_shift, p_step;
    logic [WIDTH-1:0] p_corr;

    // WIDTH-bit unsigned magnitudes are enough: |most-negative| = 2^(WIDTH-1).
    assign dvd_neg = bus.dividend[WIDTH-1];
    assign dvs_neg = bus.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign p_step  = p_q[WIDTH] ? (p_shift + d_q) : (p_shift - d_q);
    // Corrected remainder lies in [0, |divisor|), so the low WIDTH bits carry it.
    assign p_corr  = p_q[WIDTH-1:0] + (p_q[WIDTH] ? d_q[WIDTH-1:0] : '0);

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        d_d        = d_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dz_pend_d  = dz_pend_q;
        ov_pend_d  = ov_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    neg_quot_d = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
                    dz_pend_d  = (bus.divisor == '0);
                    ov_pend_d  = (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                    p_d        = '0;
                    q_d        = dvd_mag;
                    d_d        = {1'b0, dvs_mag};
                    cnt_d      = '0;
                    dz_d       = 1'b0;
                    ov_d       = 1'b0;
                    state_d    = S_ITER;
                end
            end
            S_ITER: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // With a zero divisor P has simply absorbed |dividend|, so the
                // signed remainder falls out as the original dividend.
                quot_d  = dz_pend_q ? '1 : (neg_quot_q ? (~q_q + 1'b1) : q_q);
                rem_d   = neg_rem_q ? (~p_corr + 1'b1) : p_corr;
                p_d     = {1'b0, p_corr};
                dz_d    = dz_pend_q;
                ov_d    = ov_pend_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            d_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            ov_pend_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            d_q        <= d_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dz_pend_q  <= dz_pend_d;
            ov_pend_q  <= ov_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ov_q       <= ov_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random checks of seq_signed_divider at WIDTH=8 and WIDTH=16
// against a plain-arithmetic reference of signed truncating division.
module tb_seq_signed_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    seq_signed_divider_if #(.WIDTH(8))  b8 ();
    seq_signed_divider_if #(.WIDTH(16)) b16 ();

    seq_signed_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    seq_signed_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int w, input int a, input int b,
                                  output int q, output int r, output bit dz, output bit ov);
        int mn;
        mn = -(1 << (w - 1));
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q = -1; r = a; dz = 1'b1;
        end else if (a == mn && b == -1) begin
            q = mn; r = 0; ov = 1'b1;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // One full operation: drive, count latency/busy, compare with the model.
    task automatic run_op(input int w, input int a, input int b, input string tag);
        int n, nbusy, qe, re, mask;
        bit got, dze, ove;
        logic [31:0] junk, q_o, r_o, q_hold;
        model(w, a, b, qe, re, dze, ove);
        mask = (1 << w) - 1;
        @(negedge clk);
        if (w == 8) begin b8.start = 1'b1; b8.dividend = a[7:0]; b8.divisor = b[7:0]; end
        else begin b16.start = 1'b1; b16.dividend = a[15:0]; b16.divisor = b[15:0]; end
        @(posedge clk); #1;
        junk = $urandom;
        b8.start = 1'b0;  b8.dividend = junk[7:0];   b8.divisor = junk[15:8];
        b16.start = 1'b0; b16.dividend = junk[15:0]; b16.divisor = junk[31:16];
        n = 0; got = 0;
        nbusy = (w == 8) ? int'(b8.busy) : int'(b16.busy);
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            if ((w == 8) ? b8.busy : b16.busy) nbusy++;
            if ((w == 8) ? b8.done : b16.done) got = 1;
        end
        chk({tag, "_latency"}, n, w + 1);
        chk({tag, "_busy_cycles"}, nbusy, w + 1);
        q_o = (w == 8) ? {24'b0, b8.quotient}  : {16'b0, b16.quotient};
        r_o = (w == 8) ? {24'b0, b8.remainder} : {16'b0, b16.remainder};
        chk({tag, "_q"}, q_o, qe & mask);
        chk({tag, "_r"}, r_o, re & mask);
        chk({tag, "_dz"}, (w == 8) ? b8.div_by_zero : b16.div_by_zero, dze);
        chk({tag, "_ov"}, (w == 8) ? b8.overflow : b16.overflow, ove);
        q_hold = q_o;
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, (w == 8) ? b8.done : b16.done, 1'b0);
        q_o = (w == 8) ? {24'b0, b8.quotient} : {16'b0, b16.quotient};
        chk({tag, "_q_held"}, q_o, q_hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, first, second;
        logic [31:0] t1, t2;
        b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;

        // Reset state
        #12;
        chk("rst_busy", b8.busy, 1'b0);
        chk("rst_done", b8.done, 1'b0);
        chk("rst_q", b8.quotient, 0);
        chk("rst_r", b8.remainder, 0);
        chk("rst_dz", b8.div_by_zero, 1'b0);
        chk("rst_ov", b8.overflow, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Main function and sign matrix
        run_op(8, 100, 7, "p100_p7");
        run_op(8, -100, 7, "m100_p7");
        run_op(8, 100, -7, "p100_m7");
        run_op(8, -100, -7, "m100_m7");
        run_op(8, 42, -6, "p42_m6");

        // Corners
        run_op(8, -128, -1, "m128_m1");
        run_op(8, -128, 1, "m128_p1");
        run_op(8, 5, 0, "p5_z");
        run_op(8, -128, 0, "m128_z");
        run_op(8, 0, 9, "z_p9");
        run_op(8, 3, 100, "p3_p100");
        run_op(8, 127, -128, "p127_m128");

        // Handshake: ignored starts while busy, back-to-back start in done cycle
        @(negedge clk); b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
        @(posedge clk); #1; b8.start = 1'b0;
        ndone = 0; first = 0; second = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            b8.start    = (cyc == 3 || cyc == 8 || cyc == 10);
            b8.dividend = (cyc == 10) ? 8'd50 : 8'd1;
            b8.divisor  = (cyc == 10) ? 8'd5  : 8'd1;
            @(posedge clk); #1;
            if (b8.done) begin
                ndone++;
                if (first == 0) first = cyc;
                else if (second == 0) second = cyc;
            end
            if (cyc == 9)  chk("hs_first_q", b8.quotient, 14);
            if (cyc == 15) chk("hs_hold_q", b8.quotient, 14);
            if (cyc == 15) chk("hs_hold_r", b8.remainder, 2);
        end
        b8.start = 1'b0;
        chk("hs_done_count", ndone, 2);
        chk("hs_first_edge", first, 9);
        chk("hs_second_edge", second, 19);
        chk("hs_second_q", b8.quotient, 10);
        chk("hs_second_r", b8.remainder, 0);

        // Asynchronous reset mid-operation
        @(negedge clk); b8.start = 1'b1; b8.dividend = 8'd127; b8.divisor = 8'd3;
        @(posedge clk); #1; b8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("arst_busy", b8.busy, 1'b0);
        chk("arst_done", b8.done, 1'b0);
        chk("arst_q", b8.quotient, 0);
        chk("arst_r", b8.remainder, 0);
        chk("arst_dz", b8.div_by_zero, 1'b0);
        chk("arst_ov", b8.overflow, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk); #1;
            if (b8.done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        run_op(8, 127, 3, "p127_p3");

        // Random, WIDTH=8 (zero divisors mixed in)
        for (int i = 0; i < 2000; i++) begin
            t1 = $urandom; t2 = $urandom;
            if (i % 32 == 0) t2 = 0;
            run_op(8, int'($signed(t1[7:0])), int'($signed(t2[7:0])), "rnd8");
        end

        // WIDTH=16 directed corners and random
        run_op(16, -32768, -1, "w16_ovf");
        run_op(16, -32768, 7, "w16_mn_p7");
        run_op(16, 12345, 0, "w16_dz");
        for (int i = 0; i < 300; i++) begin
            t1 = $urandom; t2 = $urandom;
            run_op(16, int'($signed(t1[15:0])), int'($signed(t2[15:0])), "rnd16");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
